// File: rtl/mmc1_pkg.sv
// Shared constants and types for the MMC1 mapper CPU-side blocks.
package mmc1_pkg;

  localparam int unsigned SHIFT_LEN = 5;
  localparam int unsigned CNT_W     = 3;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_CHR0    = 2'd1;
  localparam logic [1:0] REG_CHR1    = 2'd2;
  localparam logic [1:0] REG_PRG     = 2'd3;

  localparam logic [SHIFT_LEN-1:0] CTRL_RESET_MASK = 5'b01100;

  // Number of serial bits currently held; BIT4 means the next write commits.
  typedef enum logic [CNT_W-1:0] {
    ST_EMPTY = 3'd0,
    ST_BIT1  = 3'd1,
    ST_BIT2  = 3'd2,
    ST_BIT3  = 3'd3,
    ST_BIT4  = 3'd4
  } shift_state_e;

endpackage

// File: rtl/mmc1_write_filter.sv
// Detects CPU writes to $8000-$FFFF and suppresses the second write of a
// read-modify-write pair; D7 reset writes always pass.
module mmc1_write_filter #(
  parameter bit FILTER_CONSEC = 1'b1
) (
  input  logic CPU_M2,
  input  logic nRESET,
  input  logic nCPU_ROMSEL,
  input  logic nCPU_RW,
  input  logic CPU_D7,
  output logic accept_c,
  output logic wr_prev
);

  logic wr_event_c;

  assign wr_event_c = !nCPU_ROMSEL && !nCPU_RW;
  assign accept_c   = wr_event_c && (CPU_D7 || !(FILTER_CONSEC && wr_prev));

  // Remembers whether the previous M2 cycle carried any ROM-space write.
  always_ff @(negedge CPU_M2 or negedge nRESET) begin
    if (!nRESET) wr_prev <= 1'b0;
    else         wr_prev <= wr_event_c;
  end

endmodule

// File: rtl/mmc1_serial_port.sv
// MMC1 serial write port: assembles five D0 writes into one register value
// and emits commit / control-reset strobes on the falling M2 edge.
module mmc1_serial_port
  import mmc1_pkg::*;
#(
  parameter bit FILTER_CONSEC = 1'b1
) (
  input  logic       CPU_M2,
  input  logic       nRESET,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  output logic       REG_WE,
  output logic [1:0] REG_SEL,
  output logic [4:0] REG_DATA,
  output logic       CTRL_RESET,
  output logic [2:0] SHIFT_CNT
);

  logic                 accept_c;
  logic                 wr_prev;
  shift_state_e         state, state_nx;
  logic [SHIFT_LEN-1:0] shift_q, shift_nx, shift_in_c;
  logic                 we_nx, cr_nx;
  logic [1:0]           sel_nx;
  logic [SHIFT_LEN-1:0] data_nx;

  mmc1_write_filter #(.FILTER_CONSEC(FILTER_CONSEC)) u_filter (
    .CPU_M2      (CPU_M2),
    .nRESET      (nRESET),
    .nCPU_ROMSEL (nCPU_ROMSEL),
    .nCPU_RW     (nCPU_RW),
    .CPU_D7      (CPU_D7),
    .accept_c    (accept_c),
    .wr_prev     (wr_prev)
  );

  // New bits enter at the top so the first write ends up in bit 0.
  assign shift_in_c = {CPU_D0, shift_q[SHIFT_LEN-1:1]};
  assign SHIFT_CNT  = 3'(state);

  always_comb begin
    state_nx = state;
    shift_nx = shift_q;
    we_nx    = 1'b0;
    cr_nx    = 1'b0;
    sel_nx   = REG_SEL;
    data_nx  = REG_DATA;
    if (accept_c) begin
      if (CPU_D7) begin
        state_nx = ST_EMPTY;
        shift_nx = '0;
        cr_nx    = 1'b1;
      end else begin
        shift_nx = shift_in_c;
        case (state)
          ST_EMPTY: state_nx = ST_BIT1;
          ST_BIT1:  state_nx = ST_BIT2;
          ST_BIT2:  state_nx = ST_BIT3;
          ST_BIT3:  state_nx = ST_BIT4;
          ST_BIT4: begin
            state_nx = ST_EMPTY;
            shift_nx = '0;
            data_nx  = shift_in_c;
            sel_nx   = {CPU_A14, CPU_A13};
            we_nx    = 1'b1;
          end
          default: begin
            state_nx = ST_EMPTY;
            shift_nx = '0;
          end
        endcase
      end
    end
  end

  always_ff @(negedge CPU_M2 or negedge nRESET) begin
    if (!nRESET) begin
      state      <= ST_EMPTY;
      shift_q    <= '0;
      REG_WE     <= 1'b0;
      CTRL_RESET <= 1'b0;
      REG_SEL    <= REG_CONTROL;
      REG_DATA   <= '0;
    end else begin
      state      <= state_nx;
      shift_q    <= shift_nx;
      REG_WE     <= we_nx;
      CTRL_RESET <= cr_nx;
      REG_SEL    <= sel_nx;
      REG_DATA   <= data_nx;
    end
  end

endmodule

// File: tb/tb_mmc1_serial_port.sv
// Bench for mmc1_serial_port: filtered and unfiltered instances share one
// stimulus stream and are checked every cycle against a bit-list model.
module tb_mmc1_serial_port;

  logic CPU_M2;
  logic nRESET;
  logic nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;

  logic [1:0] we_o, cr_o;
  logic [1:0] sel_o  [2];
  logic [4:0] data_o [2];
  logic [2:0] cnt_o  [2];

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Model state, index 0 = FILTER_CONSEC=1, index 1 = FILTER_CONSEC=0.
  logic       m_prev [2];
  logic       m_we   [2];
  logic       m_cr   [2];
  logic [1:0] m_sel  [2];
  logic [4:0] m_data [2];
  logic [4:0] m_buf  [2];
  int         m_n    [2];

  initial CPU_M2 = 1'b1;
  always #5 CPU_M2 = ~CPU_M2;

  mmc1_serial_port #(.FILTER_CONSEC(1'b1)) dut (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .REG_WE(we_o[0]), .REG_SEL(sel_o[0]), .REG_DATA(data_o[0]),
    .CTRL_RESET(cr_o[0]), .SHIFT_CNT(cnt_o[0])
  );

  mmc1_serial_port #(.FILTER_CONSEC(1'b0)) dut_nf (
    .CPU_M2(CPU_M2), .nRESET(nRESET), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .REG_WE(we_o[1]), .REG_SEL(sel_o[1]), .REG_DATA(data_o[1]),
    .CTRL_RESET(cr_o[1]), .SHIFT_CNT(cnt_o[1])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      m_prev[f] = 1'b0; m_we[f] = 1'b0; m_cr[f] = 1'b0;
      m_sel[f] = 2'd0; m_data[f] = 5'd0; m_buf[f] = 5'd0; m_n[f] = 0;
    end
  endtask

  // Collect accepted bits by position; the fifth one releases them all.
  task automatic model_step(input logic romsel, input logic rw, input logic a14,
                            input logic a13, input logic d0, input logic d7);
    logic wr, acc;
    for (int f = 0; f < 2; f++) begin
      wr  = !romsel && !rw;
      acc = wr && (d7 || !((f == 0) && m_prev[f]));
      m_prev[f] = wr;
      m_we[f] = 1'b0;
      m_cr[f] = 1'b0;
      if (acc) begin
        if (d7) begin
          m_n[f] = 0;
          m_buf[f] = 5'd0;
          m_cr[f] = 1'b1;
        end else begin
          m_buf[f][m_n[f]] = d0;
          m_n[f]++;
          if (m_n[f] == 5) begin
            m_data[f] = m_buf[f];
            m_sel[f]  = {a14, a13};
            m_we[f]   = 1'b1;
            m_n[f]    = 0;
            m_buf[f]  = 5'd0;
          end
        end
      end
    end
  endtask

  always @(posedge CPU_M2) begin
    if (chk_en) begin
      for (int f = 0; f < 2; f++) begin
        chk($sformatf("reg_we[%0d]", f),     8'(we_o[f]),   8'(m_we[f]));
        chk($sformatf("ctrl_reset[%0d]", f), 8'(cr_o[f]),   8'(m_cr[f]));
        chk($sformatf("reg_sel[%0d]", f),    8'(sel_o[f]),  8'(m_sel[f]));
        chk($sformatf("reg_data[%0d]", f),   8'(data_o[f]), 8'(m_data[f]));
        chk($sformatf("shift_cnt[%0d]", f),  8'(cnt_o[f]),  8'(m_n[f]));
      end
    end
  end

  // One M2 period: drive while high, DUT and model both act on the falling edge.
  task automatic cycle(input logic romsel, input logic rw, input logic a14,
                       input logic a13, input logic d0, input logic d7);
    nCPU_ROMSEL = romsel; nCPU_RW = rw;
    CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
    @(negedge CPU_M2);
    model_step(romsel, rw, a14, a13, d0, d7);
    @(posedge CPU_M2);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic w(input logic a14, input logic a13, input logic d0);
    cycle(1'b0, 1'b0, a14, a13, d0, 1'b0);
  endtask

  task automatic wi(input logic a14, input logic a13, input logic d0);
    w(a14, a13, d0);
    idle();
  endtask

  initial begin
    logic [4:0] pat;
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
    CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    nRESET = 1'b0;
    model_reset();
    repeat (2) @(posedge CPU_M2);
    chk("rst_we", 8'(we_o[0]), 8'd0);
    chk("rst_ctrl_reset", 8'(cr_o[0]), 8'd0);
    chk("rst_sel", 8'(sel_o[0]), 8'd0);
    chk("rst_data", 8'(data_o[0]), 8'd0);
    chk("rst_cnt", 8'(cnt_o[0]), 8'd0);
    nRESET = 1'b1;
    chk_en = 1'b1;
    idle();

    // Isolated writes to $E000, D0 = 1,0,1,1,0.
    pat = 5'b01101;
    for (int i = 0; i < 4; i++) wi(1'b1, 1'b1, pat[i]);
    chk("t1_cnt_before", 8'(cnt_o[0]), 8'd4);
    w(1'b1, 1'b1, pat[4]);
    chk("t1_we", 8'(we_o[0]), 8'd1);
    chk("t1_sel", 8'(sel_o[0]), 8'd3);
    chk("t1_data", 8'(data_o[0]), 8'b01101);
    chk("t1_cnt", 8'(cnt_o[0]), 8'd0);
    idle();
    chk("t1_we_drop", 8'(we_o[0]), 8'd0);
    chk("t1_data_hold", 8'(data_o[0]), 8'b01101);

    // Three writes then a D7 reset, then five ones to $A000.
    for (int i = 0; i < 3; i++) wi(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t2_ctrl_reset", 8'(cr_o[0]), 8'd1);
    chk("t2_no_we", 8'(we_o[0]), 8'd0);
    chk("t2_cnt", 8'(cnt_o[0]), 8'd0);
    idle();
    chk("t2_ctrl_reset_drop", 8'(cr_o[0]), 8'd0);
    for (int i = 0; i < 4; i++) wi(1'b0, 1'b1, 1'b1);
    w(1'b0, 1'b1, 1'b1);
    chk("t2_we", 8'(we_o[0]), 8'd1);
    chk("t2_sel", 8'(sel_o[0]), 8'd1);
    chk("t2_data", 8'(data_o[0]), 8'b11111);
    idle();

    // Three back-to-back writes: filter keeps only the first.
    w(1'b0, 1'b0, 1'b1);
    w(1'b0, 1'b0, 1'b1);
    w(1'b0, 1'b0, 1'b1);
    idle();
    chk("t3_cnt_filtered", 8'(cnt_o[0]), 8'd1);
    chk("t3_cnt_unfiltered", 8'(cnt_o[1]), 8'd3);
    // D7 right after an accepted write still gets through.
    w(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_d7_cr_f", 8'(cr_o[0]), 8'd1);
    chk("t3_d7_cr_nf", 8'(cr_o[1]), 8'd1);
    chk("t3_d7_cnt", 8'(cnt_o[0]), 8'd0);
    idle();

    // Four writes at $8000, fifth at $C000 selects CHR1.
    pat = 5'b10010;
    for (int i = 0; i < 4; i++) wi(1'b0, 1'b0, pat[i]);
    w(1'b1, 1'b0, pat[4]);
    chk("t4_sel", 8'(sel_o[0]), 8'd2);
    chk("t4_data", 8'(data_o[0]), 8'b10010);
    idle();

    // Reset after three accepted writes, last one leaving the filter armed.
    wi(1'b1, 1'b1, 1'b1);
    wi(1'b1, 1'b1, 1'b0);
    w(1'b1, 1'b1, 1'b1);
    chk("t5_cnt_pre", 8'(cnt_o[0]), 8'd3);
    #2;
    nRESET = 1'b0;
    model_reset();
    #1;
    chk("t5_async_cnt", 8'(cnt_o[0]), 8'd0);
    chk("t5_async_sel", 8'(sel_o[0]), 8'd0);
    chk("t5_async_data", 8'(data_o[0]), 8'd0);
    chk("t5_async_we", 8'(we_o[0]), 8'd0);
    chk("t5_async_cr", 8'(cr_o[0]), 8'd0);
    @(posedge CPU_M2);
    nRESET = 1'b1;
    pat = 5'b00011;
    w(1'b1, 1'b1, pat[0]);
    chk("t5_first_after_reset", 8'(cnt_o[0]), 8'd1);
    idle();
    for (int i = 1; i < 4; i++) wi(1'b1, 1'b1, pat[i]);
    w(1'b1, 1'b1, pat[4]);
    chk("t5_we", 8'(we_o[0]), 8'd1);
    chk("t5_data", 8'(data_o[0]), 8'b00011);
    chk("t5_sel", 8'(sel_o[0]), 8'd3);
    idle();

    // Reads and non-ROM writes interleaved with a $8000 sequence.
    w(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    w(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    w(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_cnt_mid", 8'(cnt_o[0]), 8'd3);
    w(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    w(1'b0, 1'b0, 1'b0);
    chk("t6_we", 8'(we_o[0]), 8'd1);
    chk("t6_sel", 8'(sel_o[0]), 8'd0);
    chk("t6_data", 8'(data_o[0]), 8'b01110);
    chk("t6_cr", 8'(cr_o[0]), 8'd0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
